// File: rtl/axi_pmesh_pkg.sv
// Shared types and constants for the AXI-to-pmesh bridge: scheduler states,
// pmesh size codes, MSB-first base masks and AXI response codes.
package axi_pmesh_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_W = 2'd1,
    ST_SPLIT  = 2'd2,
    ST_RESP   = 2'd3
  } wsched_state_e;

  localparam logic [1:0] PMESH_SIZE_1B = 2'd0;
  localparam logic [1:0] PMESH_SIZE_2B = 2'd1;
  localparam logic [1:0] PMESH_SIZE_4B = 2'd2;
  localparam logic [1:0] PMESH_SIZE_8B = 2'd3;

  // pmesh masks are MSB-first: shifting right by the byte index places the chunk.
  localparam logic [7:0] BASE_1B = 8'h80;
  localparam logic [7:0] BASE_2B = 8'hC0;
  localparam logic [7:0] BASE_4B = 8'hF0;
  localparam logic [7:0] BASE_8B = 8'hFF;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/wstrb_chunk_pick.sv
// Combinational strobe splitter: picks the largest naturally aligned run of
// set strobe bits starting at the lowest set bit and returns what remains.
module wstrb_chunk_pick
  import axi_pmesh_pkg::*;
(
  input  logic [7:0] rem,
  output logic [2:0] idx,
  output logic [1:0] size,
  output logic [7:0] mask,
  output logic [7:0] rem_next
);

  logic [7:0] first;
  logic [7:0] shifted;
  logic [7:0] base_mask;
  logic [7:0] lane;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_first
      if (gi == 0) begin : g_lsb
        assign first[gi] = rem[gi];
      end else begin : g_upper
        assign first[gi] = rem[gi] & ~(|rem[gi-1:0]);
      end
    end
  endgenerate

  always_comb begin
    idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (first[k]) idx = 3'(k);
    end
  end

  assign shifted = rem >> idx;

  always_comb begin
    size      = PMESH_SIZE_1B;
    base_mask = BASE_1B;
    if (rem == 8'h00) begin
      base_mask = 8'h00;
    end else if (rem == 8'hFF) begin
      size      = PMESH_SIZE_8B;
      base_mask = BASE_8B;
    end else if (idx[1:0] == 2'b00 && shifted[3:0] == 4'hF) begin
      size      = PMESH_SIZE_4B;
      base_mask = BASE_4B;
    end else if (!idx[0] && shifted[1:0] == 2'b11) begin
      size      = PMESH_SIZE_2B;
      base_mask = BASE_2B;
    end
  end

  assign mask = base_mask >> idx;

  // Undo the MSB-first ordering to get the byte lanes consumed by this chunk.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign lane[gi] = mask[7-gi];
    end
  endgenerate

  assign rem_next = rem & ~lane;

endmodule

// File: rtl/axi_wstrb_sched.sv
// AXI4 write-path scheduler: splits each beat's strobe into aligned pmesh stores,
// tracks acks and returns one B per burst. Optional AXI_WSCHED_LEN_CHECK_EN adds awlen checking.
module axi_wstrb_sched
  import axi_pmesh_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int MAX_OUT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  output logic [ADDR_W-1:0]   p_addr,
  output logic [1:0]          p_size,
  output logic [7:0]          p_mask,
  output logic [DATA_W-1:0]   p_data,
  output logic                p_valid,
  input  logic                p_ready,
  input  logic                p_ack
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);

  wsched_state_e     state_reg, state_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [7:0]        beat_reg, beat_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [7:0]        rem_reg, rem_next;
  logic              last_reg, last_next;
  logic [OUT_W-1:0]  outst_reg, outst_next;
  logic              alive_reg;

`ifdef AXI_WSCHED_LEN_CHECK_EN
  logic [7:0]        len_reg, len_next;
  logic              err_reg, err_next;
`endif

  logic [2:0]        pick_idx;
  logic [1:0]        pick_size;
  logic [7:0]        pick_mask;
  logic [7:0]        pick_rem;
  logic [ADDR_W-1:0] beat_addr;
  logic              aw_hs, w_hs, p_hs, b_hs, ack_eff, stall;

  wstrb_chunk_pick u_pick (
    .rem      (rem_reg),
    .idx      (pick_idx),
    .size     (pick_size),
    .mask     (pick_mask),
    .rem_next (pick_rem)
  );

  assign stall     = (outst_reg == OUT_W'(MAX_OUT));
  assign s_awready = alive_reg && (state_reg == ST_IDLE);
  assign s_wready  = (state_reg == ST_WAIT_W);
  assign p_valid   = (state_reg == ST_SPLIT) && !stall;
  assign s_bvalid  = (state_reg == ST_RESP) && (outst_reg == '0);

  assign aw_hs   = s_awvalid && s_awready;
  assign w_hs    = s_wvalid && s_wready;
  assign p_hs    = p_valid && p_ready;
  assign b_hs    = s_bvalid && s_bready;
  // Acks with nothing outstanding are stale (e.g. from before a reset) and dropped.
  assign ack_eff = p_ack && (outst_reg != '0);

  assign beat_addr = base_reg + ADDR_W'({beat_reg, 3'b000});
  assign p_addr    = beat_addr | ADDR_W'(pick_idx);
  assign p_size    = pick_size;
  assign p_mask    = pick_mask;
  assign p_data    = data_reg;

`ifdef AXI_WSCHED_LEN_CHECK_EN
  assign s_bresp = (s_bvalid && err_reg) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  logic unused_ok;
  assign unused_ok = ^s_awaddr[2:0];
`else
  assign s_bresp = AXI_RESP_OKAY;
  logic unused_ok;
  assign unused_ok = ^{s_awaddr[2:0], s_awlen};
`endif

  always_comb begin
    state_next = state_reg;
    base_next  = base_reg;
    beat_next  = beat_reg;
    data_next  = data_reg;
    rem_next   = rem_reg;
    last_next  = last_reg;
`ifdef AXI_WSCHED_LEN_CHECK_EN
    len_next   = len_reg;
    err_next   = err_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (aw_hs) begin
          base_next  = {s_awaddr[ADDR_W-1:3], 3'b000};
          beat_next  = 8'd0;
          state_next = ST_WAIT_W;
`ifdef AXI_WSCHED_LEN_CHECK_EN
          len_next   = s_awlen;
          err_next   = 1'b0;
`endif
        end
      end
      ST_WAIT_W: begin
        if (w_hs) begin
          data_next = s_wdata;
          rem_next  = s_wstrb;
          last_next = s_wlast;
`ifdef AXI_WSCHED_LEN_CHECK_EN
          // wlast must coincide exactly with beat awlen; early or late is an error.
          if (s_wlast != (beat_reg == len_reg)) err_next = 1'b1;
`endif
          if (s_wstrb != 8'h00) begin
            state_next = ST_SPLIT;
          end else if (s_wlast) begin
            state_next = ST_RESP;
          end else begin
            beat_next = beat_reg + 8'd1;
          end
        end
      end
      ST_SPLIT: begin
        if (p_hs) begin
          rem_next = pick_rem;
          if (pick_rem == 8'h00) begin
            if (last_reg) begin
              state_next = ST_RESP;
            end else begin
              beat_next  = beat_reg + 8'd1;
              state_next = ST_WAIT_W;
            end
          end
        end
      end
      ST_RESP: begin
        if (b_hs) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    outst_next = outst_reg;
    if (p_hs && !ack_eff) begin
      outst_next = outst_reg + OUT_W'(1);
    end else if (!p_hs && ack_eff) begin
      outst_next = outst_reg - OUT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      base_reg  <= '0;
      beat_reg  <= '0;
      data_reg  <= '0;
      rem_reg   <= '0;
      last_reg  <= 1'b0;
      outst_reg <= '0;
      alive_reg <= 1'b0;
`ifdef AXI_WSCHED_LEN_CHECK_EN
      len_reg   <= '0;
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      base_reg  <= base_next;
      beat_reg  <= beat_next;
      data_reg  <= data_next;
      rem_reg   <= rem_next;
      last_reg  <= last_next;
      outst_reg <= outst_next;
      alive_reg <= 1'b1;
`ifdef AXI_WSCHED_LEN_CHECK_EN
      len_reg   <= len_next;
      err_reg   <= err_next;
`endif
    end
  end

endmodule
